// File: rtl/spi_bus_arbiter_pkg.sv
// Shared types for the two-requester SPI bus arbiter.
package spi_arb_pkg;
  localparam int N_REQ = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2,
    GAP   = 2'd3
  } arb_state_t;
endpackage

// File: rtl/spi_bus_arbiter_watchdog.sv
// Saturating hold-time counter: cleared on load, counts while enabled,
// flags expiry once the count reaches TIMEOUT_CYCLES.
module spi_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 30000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT);
endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one spi_master between two sensor controllers,
// with per-frame grants, a CS-high gap between frames and a hold watchdog.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int GAP_CYCLES     = 3,
  parameter int TIMEOUT_CYCLES = 30000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_cs_n,
  input  logic [N_REQ-1:0]   req_start,
  input  logic [N_REQ-1:0]   req_tx_valid,
  input  logic [8*N_REQ-1:0] req_tx_data,
  output logic [N_REQ-1:0]   req_tx_ready,
  output logic [N_REQ-1:0]   req_rx_valid,
  output logic [7:0]         req_rx_data,
  output logic [N_REQ-1:0]   req_busy,
  output logic               m_start,
  output logic               m_tx_valid,
  output logic [7:0]         m_tx_data,
  input  logic               m_tx_ready,
  input  logic               m_rx_valid,
  input  logic               m_busy,
  input  logic [7:0]         m_rx_data,
  output logic [N_REQ-1:0]   cs_n_out,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   timeout_err
);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  arb_state_t       state_q, state_d;
  logic             g_q, g_d;
  logic             last_q, last_d;
  logic [N_REQ-1:0] mask_q, mask_d;
  logic [N_REQ-1:0] err_q, err_d;
  logic [N_REQ-1:0] cs_q, cs_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] own;
  logic             granted;
  logic             wd_load;
  logic             wd_expired;

  spi_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (wd_load),
    .en_i      (state_q == GRANT),
    .expired_o (wd_expired)
  );

  assign req = ~req_cs_n & ~mask_q;

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    err_d   = err_q;
    gap_d   = gap_q;
    wd_load = 1'b0;
    // A masked requester is forgiven as soon as it lets its CS go high.
    mask_d  = mask_q & ~req_cs_n;
    case (state_q)
      IDLE: begin
        if (req != '0) begin
          state_d = GRANT;
          wd_load = 1'b1;
          g_d     = (req == 2'b11) ? ~last_q : req[1];
        end
      end
      GRANT: begin
        if (req_cs_n[g_q]) begin
          state_d = DRAIN;
        end else if (wd_expired) begin
          err_d[g_q]  = 1'b1;
          mask_d[g_q] = 1'b1;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        if (!m_busy) begin
          last_d  = g_q;
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Sensor CS is registered so grant and release both appear one edge later.
    cs_d = '1;
    if (state_d == GRANT) begin
      cs_d[g_d] = req_cs_n[g_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      g_q     <= 1'b0;
      last_q  <= 1'b1;
      mask_q  <= '0;
      err_q   <= '0;
      cs_q    <= '1;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
      cs_q    <= cs_d;
      gap_q   <= gap_d;
    end
  end

  assign granted = (state_q == GRANT);
  assign own     = granted ? (g_q ? 2'b10 : 2'b01) : 2'b00;

  assign grant       = ((state_q == GRANT) || (state_q == DRAIN)) ? (g_q ? 2'b10 : 2'b01) : 2'b00;
  assign cs_n_out    = cs_q;
  assign timeout_err = err_q;

  assign m_start    = granted & req_start[g_q];
  assign m_tx_valid = granted & req_tx_valid[g_q];
  assign m_tx_data  = granted ? (g_q ? req_tx_data[15:8] : req_tx_data[7:0]) : 8'h00;

  assign req_busy     = ~own | {N_REQ{m_busy}};
  assign req_tx_ready = own & {N_REQ{m_tx_ready}};
  assign req_rx_valid = own & {N_REQ{m_rx_valid}};
  assign req_rx_data  = m_rx_data;
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: directed scenarios plus random traffic,
// every cycle compared against a frame-level reference model.
module tb_spi_bus_arbiter;
  localparam int GAP = 3;
  localparam int TMO = 30000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_cs_n, req_start, req_tx_valid;
  logic [15:0] req_tx_data;
  logic [1:0]  req_tx_ready, req_rx_valid, req_busy, cs_n_out, grant, timeout_err;
  logic [7:0]  req_rx_data, m_tx_data, m_rx_data;
  logic        m_start, m_tx_valid, m_tx_ready, m_rx_valid, m_busy;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int       owner;
  bit       draining;
  int       gap_left;
  int       held;
  int       last_m;
  bit [1:0] mask_m, err_m, cs_m;
  int       rem[2];

  always #5 clk = ~clk;

  spi_bus_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_cs_n(req_cs_n), .req_start(req_start), .req_tx_valid(req_tx_valid),
    .req_tx_data(req_tx_data), .req_tx_ready(req_tx_ready), .req_rx_valid(req_rx_valid),
    .req_rx_data(req_rx_data), .req_busy(req_busy),
    .m_start(m_start), .m_tx_valid(m_tx_valid), .m_tx_data(m_tx_data),
    .m_tx_ready(m_tx_ready), .m_rx_valid(m_rx_valid), .m_busy(m_busy), .m_rx_data(m_rx_data),
    .cs_n_out(cs_n_out), .grant(grant), .timeout_err(timeout_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = -1; draining = 0; gap_left = 0; held = 0; last_m = 1;
    mask_m = 2'b00; err_m = 2'b00; cs_m = 2'b11;
  endtask

  task automatic model_step();
    bit [1:0] cs;
    bit [1:0] nmask;
    int pick;
    cs = req_cs_n;
    nmask = mask_m;
    for (int i = 0; i < 2; i++) if (cs[i]) nmask[i] = 1'b0;
    if (owner < 0 && gap_left == 0) begin
      pick = -1;
      if (!cs[0] && !mask_m[0] && !cs[1] && !mask_m[1]) pick = (last_m == 1) ? 0 : 1;
      else if (!cs[0] && !mask_m[0]) pick = 0;
      else if (!cs[1] && !mask_m[1]) pick = 1;
      if (pick >= 0) begin
        owner = pick; draining = 0; held = 0;
      end
    end else if (owner < 0) begin
      gap_left--;
    end else if (!draining) begin
      if (cs[owner]) draining = 1;
      else if (held >= TMO) begin
        err_m[owner] = 1'b1; nmask[owner] = 1'b1; draining = 1;
      end else held++;
    end else if (!m_busy) begin
      last_m = owner; owner = -1; draining = 0; gap_left = GAP;
    end
    mask_m = nmask;
    cs_m = 2'b11;
    if (owner >= 0 && !draining) cs_m[owner] = cs[owner];
  endtask

  task automatic check_all();
    bit granted;
    int idx;
    logic [1:0] g_e, busy_e, rdy_e, rxv_e;
    logic [9:0] mside_e;
    granted = (owner >= 0) && !draining;
    idx = (owner >= 0) ? owner : 0;
    g_e = (owner >= 0) ? 2'(1 << owner) : 2'b00;
    mside_e = granted ? {req_start[idx], req_tx_valid[idx], req_tx_data[idx*8 +: 8]} : 10'h0;
    for (int i = 0; i < 2; i++) begin
      bit mine;
      mine = granted && (owner == i);
      busy_e[i] = mine ? m_busy : 1'b1;
      rdy_e[i]  = mine ? m_tx_ready : 1'b0;
      rxv_e[i]  = mine ? m_rx_valid : 1'b0;
    end
    check_val("grant", 32'(grant), 32'(g_e));
    check_val("cs_n_out", 32'(cs_n_out), 32'(cs_m));
    check_val("timeout_err", 32'(timeout_err), 32'(err_m));
    check_val("master_side", 32'({m_start, m_tx_valid, m_tx_data}), 32'(mside_e));
    check_val("req_side", 32'({req_busy, req_tx_ready, req_rx_valid, req_rx_data}),
              32'({busy_e, rdy_e, rxv_e, m_rx_data}));
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_idle();
    req_cs_n = 2'b11; req_start = 2'b00; req_tx_valid = 2'b00; req_tx_data = 16'h0;
    m_tx_ready = 1'b0; m_rx_valid = 1'b0; m_busy = 1'b0; m_rx_data = 8'h00;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(owner < 0 && gap_left == 0) && n < 60) begin tick(); n++; end
    check_val("reach_idle", 32'(n < 60), 32'd1);
  endtask

  task automatic wait_grant(input logic [1:0] want, input string tag);
    int n = 0;
    while (grant !== want && n < 40) begin tick(); n++; end
    check_val(tag, 32'(grant), 32'(want));
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < 2; i++) begin
      if (rem[i] == 0) begin
        if (req_cs_n[i]) begin
          if ($urandom_range(3) == 0) begin req_cs_n[i] = 1'b0; rem[i] = int'($urandom_range(40, 1)); end
        end else begin
          req_cs_n[i] = 1'b1; rem[i] = int'($urandom_range(4, 0));
        end
      end else rem[i]--;
    end
    req_start    = 2'($urandom_range(3));
    req_tx_valid = 2'($urandom_range(3));
    req_tx_data  = 16'($urandom());
    m_tx_ready   = 1'($urandom_range(1));
    m_rx_valid   = 1'($urandom_range(1));
    m_rx_data    = 8'($urandom());
    m_busy       = ($urandom_range(3) == 0);
  endtask

  initial begin
    logic [7:0] t1_bytes [4];
    int hi, bad, n;
    t1_bytes = '{8'hA5, 8'h01, 8'h02, 8'h03};
    model_reset();
    set_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all();
    check_val("rst_busy", 32'(req_busy), 32'd3);
    rst_n = 1'b1;

    // single requester 0, four bytes
    wait_idle();
    req_cs_n = 2'b10;
    tick();
    check_val("t1_grant", 32'(grant), 32'd1);
    check_val("t1_cs", 32'(cs_n_out), 32'd2);
    m_tx_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_tx_valid = 2'b11;
      req_tx_data = {8'($urandom()), t1_bytes[k]};
      m_rx_valid = 1'b1;
      m_rx_data = 8'($urandom());
      #1;
      check_val("t1_byte", 32'(m_tx_data), 32'(t1_bytes[k]));
      check_val("t1_rxv1", 32'(req_rx_valid[1]), 32'd0);
      tick();
    end
    set_idle();
    wait_idle();

    // async reset in the middle of a byte
    req_cs_n = 2'b10;
    tick();
    m_busy = 1'b1; req_tx_valid = 2'b01; req_tx_data = 16'h005A; m_tx_ready = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_cs", 32'(cs_n_out), 32'd3);
    check_val("arst_grant", 32'(grant), 32'd0);
    model_reset();
    set_idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // simultaneous requests after reset, then gap
    req_cs_n = 2'b00;
    tick();
    check_val("t2_first", 32'(grant), 32'd1);
    repeat (3) tick();
    req_cs_n = 2'b01;
    hi = 0; n = 0;
    while (grant !== 2'b10 && n < 30) begin
      tick(); n++;
      if (cs_n_out === 2'b11) hi++;
    end
    check_val("t2_second", 32'(grant), 32'd2);
    check_val("t2_gap_ge4", 32'(hi >= GAP + 1), 32'd1);
    req_cs_n = 2'b11;
    wait_idle();

    // start from the non-granted requester is dropped
    req_cs_n = 2'b10;
    tick();
    check_val("t3_grant", 32'(grant), 32'd1);
    req_start = 2'b10;
    #1;
    check_val("t3_mstart", 32'(m_start), 32'd0);
    check_val("t3_busy1", 32'(req_busy[1]), 32'd1);
    tick();
    req_start = 2'b00;

    // release while master is still busy
    m_busy = 1'b1;
    req_cs_n = 2'b11;
    repeat (6) tick();
    check_val("t5_hold_grant", 32'(grant), 32'd1);
    check_val("t5_hold_cs", 32'(cs_n_out), 32'd3);
    m_busy = 1'b0;
    tick(); tick();
    check_val("t5_released", 32'(grant), 32'd0);
    req_cs_n = 2'b01;
    wait_grant(2'b10, "t3_req1");
    check_val("t3_noreplay", 32'(m_start), 32'd0);
    req_cs_n = 2'b11;
    wait_idle();

    // watchdog timeout
    req_cs_n = 2'b10;
    tick();
    req_cs_n = 2'b00;
    n = 0;
    while (timeout_err === 2'b00 && n < TMO + 100) begin tick(); n++; end
    check_val("t4_err", 32'(timeout_err), 32'd1);
    check_val("t4_cs0", 32'(cs_n_out[0]), 32'd1);
    wait_grant(2'b10, "t4_req1");
    req_cs_n = 2'b10;
    bad = 0;
    repeat (20) begin tick(); if (grant === 2'b01) bad++; end
    check_val("t4_masked", 32'(bad), 32'd0);
    req_cs_n = 2'b11;
    tick();
    req_cs_n = 2'b10;
    wait_grant(2'b01, "t4_regrant");
    set_idle();
    wait_idle();

    // random traffic
    rem[0] = 0; rem[1] = 0;
    repeat (4000) begin
      rand_inputs();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/spi_bus_arbiter.md
# spi_bus_arbiter

Two-requester arbiter that lets two `bno085_controller` instances share one `spi_master` (shared `sclk`/`mosi`) while each keeps its own sensor chip select. It sits between the controllers and the single SPI master in the drum trigger top level. It grants the bus round-robin per chip-select frame and enforces a minimum CS-high gap between frames. A watchdog forcibly releases a requester that holds the bus too long.

## Interface
- `GAP_CYCLES`, 3: minimum clk cycles with both `cs_n_out` high between frames (≥1).
- `TIMEOUT_CYCLES`, 30000: maximum cycles one grant may be held (10 ms at 3 MHz).
- `clk`  in  1  system clock (3 MHz HSOSC).
- `rst_n`  in  1  asynchronous active-low reset.
- `req_cs_n`  in  2  requester chip selects; low = request bus.
- `req_start`  in  2  per-requester `spi_master` start.
- `req_tx_valid`  in  2  per-requester tx byte valid.
- `req_tx_data`  in  2x8  per-requester tx byte.
- `req_tx_ready`  out  2  tx_ready, gated to the granted requester.
- `req_rx_valid`  out  2  rx_valid, gated to the granted requester.
- `req_rx_data`  out  8  rx byte, broadcast; valid only with own `req_rx_valid`.
- `req_busy`  out  2  master busy for the granted requester; forced 1 otherwise.
- `m_start`, `m_tx_valid`  out  1 each  to `spi_master`.
- `m_tx_data`  out  8  to `spi_master`.
- `m_tx_ready`, `m_rx_valid`, `m_busy`  in  1 each  from `spi_master`.
- `m_rx_data`  in  8  from `spi_master`.
- `cs_n_out`  out  2  sensor chip selects.
- `grant`  out  2  one-hot current owner; 0 when idle.
- `timeout_err`  out  2  sticky per-requester watchdog flag; cleared only by reset.

## Operation
- States: IDLE, GRANT, DRAIN, GAP.
- IDLE: `req[i] = !req_cs_n[i]`, excluding masked requesters. If one requests, grant it. If both request, grant the one not served last. `last` resets to 1, so requester 0 wins the first tie. Go to GRANT and load the watchdog.
- GRANT:
  - `cs_n_out[g] = req_cs_n[g]` and `m_* = req_*[g]`.
  - Master outputs are routed back to requester g only.
  - The non-granted requester sees `req_busy=1`, `req_tx_ready=0`, `req_rx_valid=0`, and its `cs_n_out` is held 1.
  - When `req_cs_n[g]` rises, go to DRAIN.
  - When the watchdog reaches `TIMEOUT_CYCLES`, set `timeout_err[g]`, mask g, and go to DRAIN.
- DRAIN:
  - `cs_n_out` = 11.
  - `m_start`/`m_tx_valid` are forced 0.
  - Wait for `m_busy=0`, then update `last=g` and go to GAP.
- GAP: count `GAP_CYCLES` cycles, then go to IDLE.
- Mask: a masked requester is ignored until it drives `req_cs_n` high for at least one cycle; the mask then clears.
- Requesters must wait for `req_busy=0` before pulsing start. A start issued while not granted is dropped, not queued.
- Watchdog counter is sized `$clog2(TIMEOUT_CYCLES+1)` bits, saturating, and counts only in GRANT.

## Timing
- Reset values: `grant`=00, `cs_n_out`=11, `req_busy`=11, `req_tx_ready`=00, `req_rx_valid`=00, `m_start`=0, `m_tx_valid`=0, `m_tx_data`=0, `timeout_err`=00, state IDLE.
- Request latency:
  - `req_cs_n[i]` falls at cycle t (sampled at edge t).
  - `grant`/`cs_n_out[i]` go low after edge t+1.
  - Handshake passes through from t+1.
- Handshake mux is combinational on the registered grant, so master↔requester signals have zero added latency.
- Release: `req_cs_n[g]` rising at edge t gives `cs_n_out[g]`=1 after edge t+1.
- Minimum CS-high time between two frames is `GAP_CYCLES`+1 cycles, even with a back-to-back request.
- Simultaneous requests in IDLE: round-robin as above. A request arriving during DRAIN/GAP waits for IDLE.
- Async reset mid-frame: `cs_n_out` goes 11 immediately, all outputs take their reset values, and the in-flight master transfer is abandoned (master is reset on the same `rst_n`).

## Structure
- Package `spi_arb_pkg`: `arb_state_t` enum (IDLE, GRANT, DRAIN, GAP) and `N_REQ=2`.
- Sub-module `spi_arb_watchdog`: load/enable saturating counter with `expired` output, parameter `TIMEOUT_CYCLES`.
- Top-level integration: controller 2 uses `miso2`/`cs_n2`. MISO select follows `grant` in the top level, not in this block.

## Test plan
- Single requester 0: drop `req_cs_n[0]` and transfer 4 bytes 0xA5,0x01,0x02,0x03 → `grant`=01 one cycle later, bytes appear on `m_tx_data` in order, `req_rx_valid[1]` stays 0.
- Simultaneous requests after reset → requester 0 granted first. After its release, `cs_n_out` is 11 for ≥4 cycles (GAP=3), then requester 1 is granted.
- Requester 1 pulses `req_start` while requester 0 owns the bus → `m_start` unaffected, `req_busy[1]`=1, and the start is not replayed later.
- Requester 0 holds `req_cs_n` low 30001 cycles (TIMEOUT=30000) → `timeout_err`=01, `cs_n_out[0]`=1. Requester 1 is granted despite requester 0 still holding low. Requester 0 is re-granted only after its cs goes high then low.
- Release while `m_busy`=1 → stays in DRAIN (`grant` held, `cs_n_out`=11) until `m_busy` falls, then gap.
- Assert `rst_n`=0 mid-byte → `cs_n_out`=11 and `grant`=00 immediately, with no clock edge required.
